// File: rtl/multicycle_control_unit.sv
// Multi-cycle ARM-subset control unit: Moore FSM, CondEx, NZCV register.
// Define MCU_BL_EN to add the LINK state for BL (write LR, then branch).
module multicycle_control_unit #(
    parameter int         ALUCTRL_W   = 3,
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           i_op,
    input  logic [5:0]           i_funct,
    input  logic [3:0]           i_cond,
    input  logic [3:0]           i_ALUFlags,
    input  logic                 i_MemReady,
    output logic                 o_PCWrite,
    output logic                 o_AdrSrc,
    output logic                 o_IRWrite,
    output logic                 o_MemWrite,
    output logic                 o_RegWrite,
    output logic                 o_LinkWrite,
    output logic [1:0]           o_ResultSrc,
    output logic                 o_ALUSrcA,
    output logic [1:0]           o_ALUSrcB,
    output logic [ALUCTRL_W-1:0] o_ALUControl,
    output logic [1:0]           o_ImmSrc,
    output logic [1:0]           o_RegSrc,
    output logic                 o_Undef,
    output logic [3:0]           o_flags
);

`ifdef MCU_BL_EN
    localparam logic BL_EN = 1'b1;
`else
    localparam logic BL_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_LINK
    } state_t;

    state_t     r_state, w_next;
    logic [3:0] r_flags;
    logic [3:0] w_cmd;
    logic       w_cond_ex, w_dp_ok, w_is_cmp, w_nz_only, w_flag_wr;
    logic [2:0] w_dp_ctl, w_ctl;
    logic       w_pcw, w_irw, w_mw, w_rw, w_lw, w_undef;

    assign w_cmd = i_funct[4:1];

    // ARM condition evaluation against the stored {C,V,N,Z}
    always_comb begin
        w_cond_ex = 1'b1;
        case (i_cond)
            4'h0: w_cond_ex = r_flags[0];
            4'h1: w_cond_ex = ~r_flags[0];
            4'h2: w_cond_ex = r_flags[3];
            4'h3: w_cond_ex = ~r_flags[3];
            4'h4: w_cond_ex = r_flags[1];
            4'h5: w_cond_ex = ~r_flags[1];
            4'h6: w_cond_ex = r_flags[2];
            4'h7: w_cond_ex = ~r_flags[2];
            4'h8: w_cond_ex = r_flags[3] & ~r_flags[0];
            4'h9: w_cond_ex = ~r_flags[3] | r_flags[0];
            4'hA: w_cond_ex = r_flags[1] == r_flags[2];
            4'hB: w_cond_ex = r_flags[1] != r_flags[2];
            4'hC: w_cond_ex = ~r_flags[0] & (r_flags[1] == r_flags[2]);
            4'hD: w_cond_ex = r_flags[0] | (r_flags[1] != r_flags[2]);
            default: w_cond_ex = 1'b1;
        endcase
    end

    // Data-processing command decode into ALU op and flag class
    always_comb begin
        w_dp_ok   = 1'b1;
        w_is_cmp  = 1'b0;
        w_nz_only = 1'b0;
        w_dp_ctl  = 3'b000;
        case (w_cmd)
            4'b0100: w_dp_ctl = 3'b000;
            4'b0010: w_dp_ctl = 3'b001;
            4'b1010: begin
                w_dp_ctl = 3'b001;
                w_is_cmp = 1'b1;
            end
            4'b0000: begin
                w_dp_ctl  = 3'b100;
                w_nz_only = 1'b1;
            end
            4'b1100: begin
                w_dp_ctl  = 3'b101;
                w_nz_only = 1'b1;
            end
            4'b1101: begin
                w_dp_ctl  = 3'b010;
                w_nz_only = 1'b1;
            end
            default: w_dp_ok = 1'b0;
        endcase
    end

    // Next-state and Moore outputs, defaults first
    always_comb begin
        w_next      = r_state;
        w_pcw       = 1'b0;
        w_irw       = 1'b0;
        w_mw        = 1'b0;
        w_rw        = 1'b0;
        w_lw        = 1'b0;
        w_undef     = 1'b0;
        o_AdrSrc    = 1'b0;
        o_ResultSrc = 2'b00;
        o_ALUSrcA   = 1'b0;
        o_ALUSrcB   = 2'b00;
        w_ctl       = 3'b000;
        case (r_state)
            S_FETCH: begin
                o_ALUSrcA   = 1'b1;
                o_ALUSrcB   = 2'b10;
                o_ResultSrc = 2'b10;
                w_irw       = i_MemReady;
                w_pcw       = i_MemReady;
                if (i_MemReady) w_next = S_DECODE;
            end
            S_DECODE: begin
                o_ALUSrcA = 1'b1;
                o_ALUSrcB = 2'b10;
                w_next    = S_FETCH;
                case (i_op)
                    2'b00: begin
                        if (w_dp_ok)
                            w_next = i_funct[5] ? S_EXECI : S_EXECR;
                        else
                            w_undef = 1'b1;
                    end
                    2'b01: begin
                        if (~i_funct[5] & i_funct[4] & ~i_funct[2] & ~i_funct[1])
                            w_next = S_MEMADR;
                        else
                            w_undef = 1'b1;
                    end
                    2'b10: w_next = (BL_EN & i_funct[4]) ? S_LINK : S_BRANCH;
                    default: w_undef = 1'b1;
                endcase
            end
            S_MEMADR: begin
                o_ALUSrcB = 2'b01;
                w_ctl     = i_funct[3] ? 3'b000 : 3'b001;
                w_next    = i_funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                o_AdrSrc = 1'b1;
                if (i_MemReady) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                o_ResultSrc = 2'b01;
                w_rw        = w_cond_ex;
                w_next      = S_FETCH;
            end
            S_MEMWR: begin
                o_AdrSrc = 1'b1;
                w_mw     = w_cond_ex;
                if (i_MemReady) w_next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                o_ALUSrcB = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                w_ctl     = w_dp_ctl;
                w_next    = w_is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                w_rw   = w_cond_ex;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                o_ALUSrcA   = 1'b1;
                o_ALUSrcB   = 2'b01;
                o_ResultSrc = 2'b10;
                w_pcw       = w_cond_ex;
                w_next      = S_FETCH;
            end
            S_LINK: begin
                o_ALUSrcA   = 1'b1;
                o_ALUSrcB   = 2'b11;
                o_ResultSrc = 2'b10;
                w_rw        = w_cond_ex;
                w_lw        = 1'b1;
                w_next      = S_BRANCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign w_flag_wr = (r_state == S_EXECR || r_state == S_EXECI) &
                       w_cond_ex & (i_funct[0] | w_is_cmp);

    // State register; reset returns to FETCH
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // NZCV register; logic ops leave C and V untouched
    always_ff @(posedge clk) begin
        if (reset)
            r_flags <= FLAGS_RESET;
        else if (w_flag_wr) begin
            if (w_nz_only) r_flags[1:0] <= i_ALUFlags[1:0];
            else           r_flags      <= i_ALUFlags;
        end
    end

    // Strobes are forced low during reset so no partial write escapes
    assign o_PCWrite    = w_pcw & ~reset;
    assign o_IRWrite    = w_irw & ~reset;
    assign o_MemWrite   = w_mw & ~reset;
    assign o_RegWrite   = w_rw & ~reset;
    assign o_LinkWrite  = BL_EN & w_lw & ~reset;
    assign o_Undef      = w_undef & ~reset;
    assign o_ALUControl = ALUCTRL_W'(w_ctl);
    assign o_ImmSrc     = i_op;
    assign o_RegSrc     = {(i_op == 2'b01) & ~i_funct[0], i_op == 2'b10};
    assign o_flags      = r_flags;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit with an instruction-level model.
// Expected outputs come from a per-instruction phase plan built from the ISA rules.
module tb_multicycle_control_unit;

`ifdef MCU_BL_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    localparam int PF = 0, PD = 1, PA = 2, PRD = 3, PMWB = 4, PWR = 5;
    localparam int PER = 6, PEI = 7, PWB = 8, PB = 9, PL = 10, PU = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] i_op = '0;
    logic [5:0] i_funct = '0;
    logic [3:0] i_cond = '0;
    logic [3:0] i_ALUFlags = '0;
    logic       i_MemReady = 1'b0;
    logic       o_PCWrite, o_AdrSrc, o_IRWrite, o_MemWrite, o_RegWrite;
    logic       o_LinkWrite, o_ALUSrcA, o_Undef;
    logic [1:0] o_ResultSrc, o_ALUSrcB, o_ImmSrc, o_RegSrc;
    logic [2:0] o_ALUControl;
    logic [3:0] o_flags;

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .i_op(i_op), .i_funct(i_funct),
        .i_cond(i_cond), .i_ALUFlags(i_ALUFlags), .i_MemReady(i_MemReady),
        .o_PCWrite(o_PCWrite), .o_AdrSrc(o_AdrSrc), .o_IRWrite(o_IRWrite),
        .o_MemWrite(o_MemWrite), .o_RegWrite(o_RegWrite),
        .o_LinkWrite(o_LinkWrite), .o_ResultSrc(o_ResultSrc),
        .o_ALUSrcA(o_ALUSrcA), .o_ALUSrcB(o_ALUSrcB),
        .o_ALUControl(o_ALUControl), .o_ImmSrc(o_ImmSrc),
        .o_RegSrc(o_RegSrc), .o_Undef(o_Undef), .o_flags(o_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [3:0] m_flags = 4'b0000;
    bit chk_en = 0, chk_mux = 0;
    logic e_pcw, e_irw, e_mw, e_rw, e_lw, e_un;
    logic e_adr, e_sa;
    logic [1:0] e_rs, e_sb, e_imm, e_rsrc;
    logic [2:0] e_ctl;
    logic [3:0] e_flags;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic bit condex(input logic [3:0] c, input logic [3:0] f);
        bit cc = f[3], v = f[2], n = f[1], z = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cc;
            4'h3: return !cc;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cc && !z;
            4'h9: return !cc || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            default: return 1'b1;
        endcase
    endfunction

    // ALU op code for a DP command, or -1 if the command is unsupported
    function automatic int dp_ctl(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b1010: return 1;
            4'b0000: return 4;
            4'b1100: return 5;
            4'b1101: return 2;
            default: return -1;
        endcase
    endfunction

    // The single compare process: every negedge while checking is enabled
    always @(negedge clk) begin
        if (chk_en) begin
            chk("PCWrite", int'(o_PCWrite), int'(e_pcw));
            chk("IRWrite", int'(o_IRWrite), int'(e_irw));
            chk("MemWrite", int'(o_MemWrite), int'(e_mw));
            chk("RegWrite", int'(o_RegWrite), int'(e_rw));
            chk("LinkWrite", int'(o_LinkWrite), int'(e_lw));
            chk("Undef", int'(o_Undef), int'(e_un));
            if (chk_mux) begin
                chk("AdrSrc", int'(o_AdrSrc), int'(e_adr));
                chk("ResultSrc", int'(o_ResultSrc), int'(e_rs));
                chk("ALUSrcA", int'(o_ALUSrcA), int'(e_sa));
                chk("ALUSrcB", int'(o_ALUSrcB), int'(e_sb));
                chk("ALUControl", int'(o_ALUControl), int'(e_ctl));
                chk("ImmSrc", int'(o_ImmSrc), int'(e_imm));
                chk("RegSrc", int'(o_RegSrc), int'(e_rsrc));
                chk("flags", int'(o_flags), int'(e_flags));
            end
        end
    end

    // One reset cycle with all strobes expected low; called just after a posedge+1
    task automatic reset_cycle();
        reset = 1'b1;
        i_MemReady = 1'b0;
        i_op = 2'($urandom);
        i_funct = 6'($urandom);
        i_cond = 4'($urandom);
        i_ALUFlags = 4'($urandom);
        {e_pcw, e_irw, e_mw, e_rw, e_lw, e_un} = '0;
        chk_mux = 0;
        chk_en = 1;
        @(posedge clk);
        m_flags = 4'b0000;
        #1;
        reset = 1'b0;
    endtask

    // Runs one instruction; fw/mw = not-ready cycles (-1 random), af -1 random
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] cond, input int af,
                             input int fw, input int mw, input int rst_at,
                             output int cyc, output int n_mw, output int n_rw,
                             output int n_lw, output int n_un, output int n_pcw);
        int plan[$];
        int pos = 0, wcnt = 0, p, lim, ctl;
        bit waitp, rdy, cx;
        logic [3:0] afv;
        ctl = dp_ctl(fn[4:1]);
        plan = {PF};
        if (op == 2'b00 && ctl >= 0) begin
            plan.push_back(PD);
            plan.push_back(fn[5] ? PEI : PER);
            if (fn[4:1] != 4'b1010) plan.push_back(PWB);
        end else if (op == 2'b01 && !fn[5] && fn[4] && !fn[2] && !fn[1]) begin
            plan.push_back(PD);
            plan.push_back(PA);
            if (fn[0]) begin
                plan.push_back(PRD);
                plan.push_back(PMWB);
            end else plan.push_back(PWR);
        end else if (op == 2'b10) begin
            plan.push_back(PD);
            if (BL && fn[4]) plan.push_back(PL);
            plan.push_back(PB);
        end else plan.push_back(PU);
        {cyc, n_mw, n_rw, n_lw, n_un, n_pcw} = '0;
        while (pos < plan.size()) begin
            if (cyc == rst_at) begin
                reset_cycle();
                cyc++;
                return;
            end
            p = plan[pos];
            waitp = (p == PF || p == PRD || p == PWR);
            lim = (p == PF) ? fw : mw;
            if (waitp) rdy = (lim < 0) ? ($urandom_range(2) != 0) : (wcnt >= lim);
            else rdy = 1'($urandom);
            afv = (af < 0) ? 4'($urandom) : 4'(af);
            reset = 1'b0;
            i_MemReady = rdy;
            i_ALUFlags = afv;
            if (p == PF) begin
                i_op = 2'($urandom);
                i_funct = 6'($urandom);
                i_cond = 4'($urandom);
            end else begin
                i_op = op;
                i_funct = fn;
                i_cond = cond;
            end
            cx = condex(i_cond, m_flags);
            {e_pcw, e_irw, e_mw, e_rw, e_lw, e_un} = '0;
            {e_adr, e_sa, e_rs, e_sb, e_ctl} = '0;
            e_imm = i_op;
            e_rsrc = {i_op == 2'b01 && !i_funct[0], i_op == 2'b10};
            e_flags = m_flags;
            case (p)
                PF: begin
                    e_sa = 1; e_sb = 2; e_rs = 2;
                    e_pcw = rdy; e_irw = rdy;
                end
                PD: begin e_sa = 1; e_sb = 2; end
                PU: begin e_sa = 1; e_sb = 2; e_un = 1; end
                PA: begin e_sb = 1; e_ctl = fn[3] ? 3'd0 : 3'd1; end
                PRD: e_adr = 1;
                PMWB: begin e_rs = 1; e_rw = cx; end
                PWR: begin e_adr = 1; e_mw = cx; end
                PER: e_ctl = 3'(ctl);
                PEI: begin e_sb = 1; e_ctl = 3'(ctl); end
                PWB: e_rw = cx;
                PB: begin e_sa = 1; e_sb = 1; e_rs = 2; e_pcw = cx; end
                PL: begin e_sa = 1; e_sb = 3; e_rs = 2; e_rw = cx; e_lw = 1; end
                default: ;
            endcase
            chk_mux = 1;
            chk_en = 1;
            #3;
            n_mw += int'(o_MemWrite);
            n_rw += int'(o_RegWrite);
            n_lw += int'(o_LinkWrite);
            n_un += int'(o_Undef);
            n_pcw += int'(o_PCWrite);
            @(posedge clk);
            if ((p == PER || p == PEI) && cx && (fn[0] || fn[4:1] == 4'b1010)) begin
                if (ctl == 0 || ctl == 1) m_flags = afv;
                else m_flags[1:0] = afv[1:0];
            end
            if (waitp && !rdy) wcnt++;
            else begin
                pos++;
                wcnt = 0;
            end
            cyc++;
            #1;
            if (cyc > 300) begin
                chk("instr_timeout", cyc, 300);
                return;
            end
        end
    endtask

    int cyc, nmw, nrw, nlw, nun, npcw;
    logic [1:0] rop;
    logic [5:0] rfn;
    logic [3:0] cmds[6] = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b1101};

    initial begin
        @(posedge clk);
        #1;
        reset_cycle();
        reset_cycle();
        chk("reset_flags", int'(o_flags), 0);

        // ADDS with ALUFlags 0101
        run_instr(2'b00, 6'b001001, 4'hE, 5, 0, 0, -1, cyc, nmw, nrw, nlw, nun, npcw);
        chk("adds_cycles", cyc, 4);
        chk("adds_regwrite_cnt", nrw, 1);
        chk("adds_flags", int'(o_flags), 5);

        // CMP producing Z=1, then BNE not taken
        run_instr(2'b00, 6'b010101, 4'hE, 1, 0, 0, -1, cyc, nmw, nrw, nlw, nun, npcw);
        chk("cmp_cycles", cyc, 3);
        chk("cmp_flags", int'(o_flags), 1);
        run_instr(2'b10, 6'b000000, 4'h1, -1, 0, 0, -1, cyc, nmw, nrw, nlw, nun, npcw);
        chk("bne_cycles", cyc, 3);
        chk("bne_pcwrite_cnt", npcw, 1);

        // LDR with two wait states in MEMRD
        run_instr(2'b01, 6'b011001, 4'hE, -1, 0, 2, -1, cyc, nmw, nrw, nlw, nun, npcw);
        chk("ldr_cycles", cyc, 7);
        chk("ldr_regwrite_cnt", nrw, 1);

        // STR with three wait states
        run_instr(2'b01, 6'b011000, 4'hE, -1, 0, 3, -1, cyc, nmw, nrw, nlw, nun, npcw);
        chk("str_memwrite_cnt", nmw, 4);
        chk("str_cycles", cyc, 7);

        // Undefined op=11
        run_instr(2'b11, 6'b000000, 4'hE, -1, 0, 0, -1, cyc, nmw, nrw, nlw, nun, npcw);
        chk("undef_cycles", cyc, 2);
        chk("undef_pulse_cnt", nun, 1);
        chk("undef_writes", nmw + nrw, 0);

        // BL always
        run_instr(2'b10, 6'b010000, 4'hE, -1, 0, 0, -1, cyc, nmw, nrw, nlw, nun, npcw);
        chk("bl_cycles", cyc, BL ? 4 : 3);
        chk("bl_link_cnt", nlw, BL ? 1 : 0);

        // Reset while stalled in MEMRD, then a FETCH with memory not ready
        run_instr(2'b00, 6'b001001, 4'hE, 15, 0, 0, -1, cyc, nmw, nrw, nlw, nun, npcw);
        run_instr(2'b01, 6'b011001, 4'hE, -1, 0, 5, 4, cyc, nmw, nrw, nlw, nun, npcw);
        chk("midrst_cycles", cyc, 5);
        chk("midrst_flags", int'(o_flags), 0);
        run_instr(2'b10, 6'b000000, 4'hE, -1, 1, 0, -1, cyc, nmw, nrw, nlw, nun, npcw);
        chk("post_rst_b_cycles", cyc, 4);

        // Randomized instruction stream
        for (int k = 0; k < 400; k++) begin
            rop = 2'($urandom);
            rfn = 6'($urandom);
            if (rop == 2'b01 && $urandom_range(1) == 1) begin
                rfn[5] = 0; rfn[4] = 1; rfn[2] = 0; rfn[1] = 0;
            end
            if (rop == 2'b00 && $urandom_range(3) != 0)
                rfn[4:1] = cmds[$urandom_range(5)];
            run_instr(rop, rfn, 4'($urandom), -1, -1, -1,
                      ($urandom_range(24) == 0) ? int'($urandom_range(5)) : -1,
                      cyc, nmw, nrw, nlw, nun, npcw);
        end

        chk_en = 0;
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
